// File: rtl/btn_press_decoder_pkg.sv
//==============================================================================
// Module : btn_pkg
// Brief  : Shared state encoding and default timing constants for the
//          front-panel button press decoder and its debouncer site.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package btn_pkg;

    localparam int WINDOW_CYCLES_DEF = 25_000_000;
    localparam int MAX_PRESSES_DEF   = 3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/btn_press_decoder_if.sv
//==============================================================================
// Module : btn_press_decoder_if
// Brief  : Press strobe in, burst event out, plus burst-open indicator.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface btn_press_decoder_if
    import btn_pkg::*;
#(
    parameter int MAX_PRESSES = MAX_PRESSES_DEF
) ();

    localparam int CW = $clog2(MAX_PRESSES + 1);

    logic          pressPulse;
    logic          evtValid;
    logic [CW-1:0] evtCount;
    logic          busy;

    modport master (
        output pressPulse,
        input  evtValid,
        input  evtCount,
        input  busy
    );

    modport slave (
        input  pressPulse,
        output evtValid,
        output evtCount,
        output busy
    );

endinterface

`default_nettype wire

// File: rtl/btn_press_decoder.sv
//==============================================================================
// Module : btn_press_decoder
// Brief  : Groups debounced press strobes into single/double/.../N-press
//          events, closing a burst on gap timeout or on reaching MAX_PRESSES.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module btn_press_decoder
    import btn_pkg::*;
#(
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int MAX_PRESSES   = MAX_PRESSES_DEF
) (
    input  logic                 clk,
    input  logic                 rstN,
    btn_press_decoder_if.slave   bus
);

    localparam int CW = $clog2(MAX_PRESSES + 1);
    localparam int TW = $clog2(WINDOW_CYCLES);

    localparam logic [TW-1:0] c_TMR_LAST = TW'(WINDOW_CYCLES - 1);
    localparam logic [TW-1:0] c_TMR_ONE  = TW'(1);
    localparam logic [CW-1:0] c_CNT_MAX  = CW'(MAX_PRESSES);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   tmr_q;
    logic            evt_valid_q;
    logic [CW-1:0]   evt_count_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_count_q <= '0;
        end else begin
            // Event outputs are one-cycle strobes unless reloaded below.
            evt_valid_q <= 1'b0;
            evt_count_q <= '0;

            case (state_q)
                IDLE: begin
                    if (bus.pressPulse) begin
                        if (MAX_PRESSES == 1) begin
                            evt_valid_q <= 1'b1;
                            evt_count_q <= c_CNT_ONE;
                        end else begin
                            state_q <= COLLECT;
                            cnt_q   <= c_CNT_ONE;
                            tmr_q   <= '0;
                        end
                    end
                end

                COLLECT: begin
                    // A press in the timeout cycle takes priority over closing.
                    if (bus.pressPulse) begin
                        if (cnt_q + c_CNT_ONE == c_CNT_MAX) begin
                            evt_valid_q <= 1'b1;
                            evt_count_q <= c_CNT_MAX;
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                            tmr_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + c_CNT_ONE;
                            tmr_q <= '0;
                        end
                    end else if (tmr_q == c_TMR_LAST) begin
                        evt_valid_q <= 1'b1;
                        evt_count_q <= cnt_q;
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        tmr_q       <= '0;
                    end else begin
                        tmr_q <= tmr_q + c_TMR_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    tmr_q   <= '0;
                end
            endcase
        end
    end

    assign bus.busy     = (state_q == COLLECT);
    assign bus.evtValid = evt_valid_q;
    assign bus.evtCount = evt_count_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_press_decoder.sv
//==============================================================================
// Module : tb_btn_press_decoder
// Brief  : Bench for btn_press_decoder (WINDOW=8, MAX=3 and MAX=1 builds).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_btn_press_decoder;

    localparam int W = 8;

    logic clk;
    logic rstN;

    btn_press_decoder_if #(.MAX_PRESSES(3)) ifc0 ();
    btn_press_decoder_if #(.MAX_PRESSES(1)) ifc1 ();

    btn_press_decoder #(.WINDOW_CYCLES(W), .MAX_PRESSES(3)) u_dut3 (
        .clk  (clk),
        .rstN (rstN),
        .bus  (ifc0.slave)
    );

    btn_press_decoder #(.WINDOW_CYCLES(W), .MAX_PRESSES(1)) u_dut1 (
        .clk  (clk),
        .rstN (rstN),
        .bus  (ifc1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a burst is a list of press times; it closes W ticks after
    // its latest press, or immediately once it holds maxp presses.
    int  maxp   [2] = '{3, 1};
    bit  m_open [2];
    int  m_n    [2];
    int  m_last [2];
    bit  ev_v   [2];
    int  ev_c   [2];
    int  now = 0;

    int  rel, first_ev, first_cnt, seen_n, first1, seen1_n;
    bit  busy1_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, now);
        end
    endtask

    task automatic model_edge(input int k, input bit p);
        ev_v[k] = 1'b0;
        ev_c[k] = 0;
        if (!rstN) begin
            m_open[k] = 1'b0;
            m_n[k]    = 0;
        end else if (!m_open[k]) begin
            if (p) begin
                if (maxp[k] == 1) begin
                    ev_v[k] = 1'b1;
                    ev_c[k] = 1;
                end else begin
                    m_open[k] = 1'b1;
                    m_n[k]    = 1;
                    m_last[k] = now;
                end
            end
        end else if (p) begin
            if (m_n[k] + 1 == maxp[k]) begin
                ev_v[k]   = 1'b1;
                ev_c[k]   = maxp[k];
                m_open[k] = 1'b0;
                m_n[k]    = 0;
            end else begin
                m_n[k]    = m_n[k] + 1;
                m_last[k] = now;
            end
        end else if (now - m_last[k] == W) begin
            ev_v[k]   = 1'b1;
            ev_c[k]   = m_n[k];
            m_open[k] = 1'b0;
            m_n[k]    = 0;
        end
    endtask

    task automatic tick(input bit p0, input bit p1);
        ifc0.pressPulse = p0;
        ifc1.pressPulse = p1;
        @(posedge clk);
        now++;
        model_edge(0, p0);
        model_edge(1, p1);
        #1;
        chk("valid3", 32'(ifc0.evtValid), 32'(ev_v[0]));
        chk("count3", 32'(ifc0.evtCount), 32'(ev_c[0]));
        chk("busy3",  32'(ifc0.busy),     32'(m_open[0]));
        chk("valid1", 32'(ifc1.evtValid), 32'(ev_v[1]));
        chk("count1", 32'(ifc1.evtCount), 32'(ev_c[1]));
        chk("busy1",  32'(ifc1.busy),     32'(m_open[1]));
        if (ifc0.evtValid === 1'b1) begin
            seen_n++;
            if (first_ev < 0) begin
                first_ev  = rel;
                first_cnt = int'(ifc0.evtCount);
            end
        end
        if (ifc1.evtValid === 1'b1) begin
            seen1_n++;
            if (first1 < 0) first1 = rel;
        end
        if (ifc1.busy !== 1'b0) busy1_seen = 1'b1;
        rel++;
        ifc0.pressPulse = 1'b0;
        ifc1.pressPulse = 1'b0;
    endtask

    task automatic begin_seq();
        rel = 0; first_ev = -1; first_cnt = -1; seen_n = 0;
        first1 = -1; seen1_n = 0; busy1_seen = 1'b0;
    endtask

    task automatic run_seq(input logic [31:0] mask0, input logic [31:0] mask1, input int len);
        begin_seq();
        for (int r = 0; r < len; r++) tick(mask0[r], mask1[r]);
    endtask

    task automatic apply_reset(input int ncyc);
        rstN = 1'b0;
        #1;
        chk("rst_valid", 32'(ifc0.evtValid), 32'd0);
        chk("rst_count", 32'(ifc0.evtCount), 32'd0);
        chk("rst_busy",  32'(ifc0.busy),     32'd0);
        m_open[0] = 1'b0; m_n[0] = 0;
        m_open[1] = 1'b0; m_n[1] = 0;
        for (int i = 0; i < ncyc; i++) tick(1'b0, 1'b0);
        rstN = 1'b1;
    endtask

    initial begin
        int dens;
        rstN = 1'b0;
        ifc0.pressPulse = 1'b0;
        ifc1.pressPulse = 1'b0;
        begin_seq();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        rstN = 1'b1;

        // Single press: timeout event W ticks later with count 1.
        run_seq(32'h1, 32'h0, 20);
        chk("t1_rel",  32'(first_ev),  32'(W));
        chk("t1_cnt",  32'(first_cnt), 32'd1);
        chk("t1_nevt", 32'(seen_n),    32'd1);

        // Presses 5 apart: one event, count 2, timed from the second press.
        run_seq(32'h21, 32'h0, 25);
        chk("t2_rel",  32'(first_ev),  32'(5 + W));
        chk("t2_cnt",  32'(first_cnt), 32'd2);
        chk("t2_nevt", 32'(seen_n),    32'd1);

        // Third press closes immediately; no trailing timeout.
        run_seq(32'hD, 32'h0, 20);
        chk("t3_rel",  32'(first_ev),  32'd3);
        chk("t3_cnt",  32'(first_cnt), 32'd3);
        chk("t3_nevt", 32'(seen_n),    32'd1);

        // Press on the exact timeout edge wins and extends the burst.
        run_seq(32'h101, 32'h0, 28);
        chk("t4_rel",  32'(first_ev),  32'(2 * W));
        chk("t4_cnt",  32'(first_cnt), 32'd2);
        chk("t4_nevt", 32'(seen_n),    32'd1);

        // Reset mid-burst discards it.
        begin_seq();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        apply_reset(2);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
        chk("t5_nevt", 32'(seen_n), 32'd0);

        // MAX_PRESSES=1 build: each press is its own event, never busy.
        run_seq(32'h0, 32'h3, 6);
        chk("t6_rel",  32'(first1),     32'd0);
        chk("t6_nevt", 32'(seen1_n),    32'd2);
        chk("t6_busy", 32'(busy1_seen), 32'd0);

        // Back-to-back presses on consecutive ticks reach max in three edges.
        run_seq(32'h7, 32'h0, 14);
        chk("t7_rel",  32'(first_ev),  32'd2);
        chk("t7_cnt",  32'(first_cnt), 32'd3);

        // Randomized traffic with varying press density and one mid-run reset.
        for (int blk = 0; blk < 12; blk++) begin
            case ($urandom_range(0, 2))
                0:       dens = 5;
                1:       dens = 15;
                default: dens = 45;
            endcase
            begin_seq();
            for (int i = 0; i < 40; i++)
                tick($urandom_range(0, 99) < dens, $urandom_range(0, 99) < dens);
            if (blk == 6) apply_reset(1 + $urandom_range(0, 2));
        end
        for (int i = 0; i < 2 * W; i++) tick(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
